obi_mem_arbiter: RTL

Two-to-one OBI arbiter that lets the core's instruction fetch port and data load/store port share one memory port of the mm_ram class.
- Requests are granted one per cycle.
- The requester ID of every accepted request is recorded in an in-order FIFO, so each memory response is routed back to the port that issued it.
- The block sits between the core and the memory subsystem for single-port memory configurations of the test subsystem.

---
 rtl/obi_mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   Two-to-one OBI arbiter sharing one memory port between the core's
//   instruction fetch port and its data load/store port. One request is
//   granted per cycle. The requester ID of every accepted request is kept in
//   an in-order FIFO so each memory response is routed back to its issuer.
//
// Build option:
//   OBI_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests in IDLE are
//   resolved round-robin (the port that did not win the last handshake wins).
//   When undefined, the data port has fixed priority.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   instr_*                 instruction fetch OBI port (read-only)
//   data_*                  data load/store OBI port
//   mem_*                   shared memory OBI port
//   outstanding_o           number of accepted requests awaiting a response
//   resp_err_o              sticky: a response arrived with nothing in flight
module obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   instr_req_i,
  output logic                                   instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
  output logic                                   instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  instr_rdata_o,
  input  logic                                   data_req_i,
  output logic                                   data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
  input  logic                                   data_we_i,
  input  logic [DATA_WIDTH/8-1:0]                data_be_i,
  input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
  output logic                                   data_rvalid_o,
  output logic [DATA_WIDTH-1:0]                  data_rdata_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic                                   mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   resp_err_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  typedef enum logic {S_IDLE, S_LOCKED} lock_state_e;

  lock_state_e    state_q, state_d;
  logic           lock_id_q, lock_id_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;
  logic           id_mem_q [MAX_OUTSTANDING];

  logic           locked_valid;
  logic           winner;
  logic           fifo_full;
  logic           fifo_empty;
  logic           handshake;
  logic           push;
  logic           pop;
  logic           head_id;

  // Pointer wrap that also works when the depth is 1 (pointer stays at 0).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    else                               return p + PW'(1);
  endfunction

`ifdef OBI_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  assign last_grant_d = handshake ? winner : last_grant_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_grant_q <= ID_INSTR;
    else       last_grant_q <= last_grant_d;
  end
`endif

  // A held request only stays forced while its owner keeps requesting; if
  // the owner drops req, selection falls back to normal arbitration.
  always_comb begin
    locked_valid = (state_q == S_LOCKED) &&
                   ((lock_id_q == ID_DATA) ? data_req_i : instr_req_i);
    winner = ID_INSTR;
    if (locked_valid) begin
      winner = lock_id_q;
    end else if (instr_req_i && data_req_i) begin
`ifdef OBI_ARB_ROUND_ROBIN_EN
      winner = ~last_grant_q;
`else
      winner = ID_DATA;
`endif
    end else if (data_req_i) begin
      winner = ID_DATA;
    end
  end

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // No forwarding when full, even if a response frees a slot this cycle.
  assign mem_req_o  = (instr_req_i | data_req_i) & ~fifo_full;
  assign handshake  = mem_req_o & mem_gnt_i;
  assign push       = handshake;
  assign pop        = mem_rvalid_i & ~fifo_empty;
  assign head_id    = id_mem_q[rptr_q];

  assign mem_addr_o  = (winner == ID_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (winner == ID_DATA) ? data_we_i    : 1'b0;
  assign mem_be_o    = (winner == ID_DATA) ? data_be_i    : {BE_W{1'b1}};
  assign mem_wdata_o = (winner == ID_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o    = handshake & (winner == ID_INSTR);
  assign data_gnt_o     = handshake & (winner == ID_DATA);
  assign instr_rvalid_o = pop & (head_id == ID_INSTR);
  assign data_rvalid_o  = pop & (head_id == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign outstanding_o  = count_q;
  assign resp_err_o     = err_q;

  // Lock FSM: keeps the mem_* fields stable while a request waits for gnt.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d   = S_LOCKED;
          lock_id_d = winner;
        end
      end
      S_LOCKED: begin
        if (!locked_valid) begin
          // Owner abandoned its request; re-arbitrate as if idle.
          if (mem_req_o && !mem_gnt_i) lock_id_d = winner;
          else                         state_d   = S_IDLE;
        end else if (handshake) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (mem_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      lock_id_q <= ID_INSTR;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wptr_q] <= winner;
  end

endmodule
